// File: rtl/demux_lane_collector.sv
// Purpose: reassembles the four demux lanes into WIDTH-bit words, MSB first, one word per channel.
// Latency: the WIDTH-th bit of a word is captured at edge N; with the output slot free, out_valid rises after edge N+1.
// Backpressure: while out_ready is low the output holds; each channel keeps one finished word and drops further bits (overflow).
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   bit_valid           lane_sel / lane_in carry one bit this cycle
//   lane_sel[1:0]       demux select in effect for the strobed bit
//   lane_in[3:0]        demux output lanes y[3:0]
//   out_valid/out_ready registered valid/ready output handshake
//   out_data[WIDTH-1:0] assembled word, first-received bit in the MSB
//   out_ch[1:0]         source channel of out_data
//   overflow[3:0]       sticky per-channel bit-drop flag
//   lane_err            sticky: a lane other than lane_sel was high on a strobe

module demux_lane_collector #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic [1:0]       lane_sel,
    input  logic [3:0]       lane_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_ch,
    output logic [3:0]       overflow,
    output logic             lane_err
);

    localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef struct packed {
        logic [1:0]       ch;
        logic [WIDTH-1:0] data;
    } word_t;

    // Per-channel assembly state. A full channel holds its finished word in
    // sr with cnt back at zero, so a drain and a fresh first bit can share an edge.
    logic [WIDTH-1:0] sr   [NCH];
    logic [CW-1:0]    cnt  [NCH];
    logic [NCH-1:0]   full;
    logic [1:0]       ptr;
    word_t            out_word;
    logic             out_vld_q;
    logic [3:0]       ovf_q;
    logic             lane_err_q;

    // Output slot and round-robin grant
    logic             slot_free;
    logic             gnt_any;
    logic [1:0]       gnt_idx;
    logic [1:0]       scan;
    logic [NCH-1:0]   drain;

    // Capture decode
    logic [NCH-1:0]   sel_oh;
    logic             cap_bit;
    logic             cap_ok;
    logic             cap_drop;
    logic             stray;
    logic [NCH-1:0]   complete;

    assign out_valid = out_vld_q;
    assign out_data  = out_word.data;
    assign out_ch    = out_word.ch;
    assign overflow  = ovf_q;
    assign lane_err  = lane_err_q;

    // The slot can take a new word when it is empty or being consumed now.
    assign slot_free = !out_vld_q || out_ready;

    // First full channel scanning ptr, ptr+1, ... with 2-bit wraparound.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr;
        scan    = ptr;
        for (int i = 0; i < NCH; i++) begin
            scan = ptr + 2'(i);
            if (!gnt_any && full[scan]) begin
                gnt_any = 1'b1;
                gnt_idx = scan;
            end
        end
    end

    always_comb begin
        drain = '0;
        if (slot_free && gnt_any) begin
            drain[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_oh           = '0;
        sel_oh[lane_sel] = 1'b1;
    end

    assign cap_bit  = lane_in[lane_sel];
    // A full channel accepts a bit only when its word is leaving this edge.
    assign cap_ok   = bit_valid && (!full[lane_sel] || drain[lane_sel]);
    assign cap_drop = bit_valid && full[lane_sel] && !drain[lane_sel];
    assign stray    = bit_valid && (|(lane_in & ~sel_oh));

    always_comb begin
        complete = '0;
        if (cap_ok && (cnt[lane_sel] == CNT_LAST)) begin
            complete = sel_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_word   <= '0;
            ptr        <= 2'd0;
            full       <= '0;
            ovf_q      <= '0;
            lane_err_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                sr[c]  <= '0;
                cnt[c] <= '0;
            end
        end else begin
            // Output slot: load the granted word or go empty; hold otherwise.
            if (slot_free) begin
                if (gnt_any) begin
                    out_word.data <= sr[gnt_idx];
                    out_word.ch   <= gnt_idx;
                    out_vld_q     <= 1'b1;
                    ptr           <= gnt_idx + 2'd1;
                end else begin
                    out_vld_q <= 1'b0;
                end
            end

            // Bit capture. sr[gnt_idx] above reads the pre-edge word, so a
            // drained channel can shift in the first bit of its next word here.
            for (int c = 0; c < NCH; c++) begin
                if (cap_ok && (lane_sel == 2'(c))) begin
                    sr[c] <= {sr[c][WIDTH-2:0], cap_bit};
                    if (cnt[c] == CNT_LAST) begin
                        cnt[c] <= '0;
                    end else begin
                        cnt[c] <= cnt[c] + CW'(1);
                    end
                end
            end

            full <= (full & ~drain) | complete;

            if (cap_drop) begin
                ovf_q <= ovf_q | sel_oh;
            end
            if (stray) begin
                lane_err_q <= 1'b1;
            end
        end
    end

    // A word presented under backpressure must not change until taken.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));

    // A full channel always has its bit counter parked at zero.
    for (genvar g = 0; g < NCH; g++) begin : g_full_cnt
        a_full_cnt_zero: assert property (@(posedge clk) disable iff (!rst_n)
            full[g] |-> (cnt[g] == '0));
    end

endmodule

// File: tb/tb_demux_lane_collector.sv
module tb_demux_lane_collector;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bit_valid;
    logic [1:0]   lane_sel;
    logic [3:0]   lane_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_ch;
    logic [3:0]   overflow;
    logic         lane_err;

    int checks = 0;
    int errors = 0;

    demux_lane_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (bit_valid),
        .lane_sel  (lane_sel),
        .lane_in   (lane_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .overflow  (overflow),
        .lane_err  (lane_err)
    );

    always #5 clk = ~clk;

    // Reference model: bit counts and accumulated values per channel, one
    // parked finished word per channel, and a single output slot.
    int       m_acc  [4];
    int       m_nb   [4];
    int       m_word [4];
    bit       m_full [4];
    bit [3:0] m_ov;
    bit       m_le;
    bit       m_vld;
    int       m_dat;
    int       m_ch;
    int       m_ptr;

    task automatic model_edge();
        bit       fr;
        int       g;
        int       k;
        int       c;
        int       b;
        logic [3:0] mask;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_acc[i] = 0; m_nb[i] = 0; m_word[i] = 0; m_full[i] = 0;
            end
            m_ov = '0; m_le = 0; m_vld = 0; m_dat = 0; m_ch = 0; m_ptr = 0;
        end else begin
            fr = !m_vld || out_ready;
            g = -1;
            for (int i = 0; i < 4; i++) begin
                k = (m_ptr + i) % 4;
                if (g < 0 && m_full[k]) g = k;
            end
            if (fr) begin
                if (g >= 0) begin
                    m_vld = 1; m_dat = m_word[g]; m_ch = g;
                    m_full[g] = 0; m_ptr = (g + 1) % 4;
                end else begin
                    m_vld = 0;
                end
            end
            if (bit_valid) begin
                c = int'(lane_sel);
                b = int'(lane_in[c]);
                mask = 4'b0001 << c;
                if ((lane_in & ~mask) != 4'b0000) m_le = 1;
                // m_full is already cleared for a channel drained this edge.
                if (m_full[c]) begin
                    m_ov[c] = 1'b1;
                end else begin
                    m_acc[c] = ((m_acc[c] << 1) | b) & ((1 << W) - 1);
                    m_nb[c]++;
                    if (m_nb[c] == W) begin
                        m_word[c] = m_acc[c]; m_full[c] = 1; m_nb[c] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input int ch, input logic b);
        bit_valid = 1'b1;
        lane_sel  = 2'(ch);
        lane_in   = 4'({3'b000, b}) << ch;
        step();
    endtask

    task automatic idle();
        bit_valid = 1'b0;
        lane_in   = 4'b0000;
        step();
    endtask

    task automatic send_byte(input int ch, input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send(ch, v[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bit_valid = 1'b0; lane_in = 4'b0000; lane_sel = 2'd0; out_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        lane_sel = 2'd1; lane_in = 4'b1010; bit_valid = 1'b1;
        step();
        send_byte(1, 8'h5A);
        send_byte(1, 8'h33);
        send(1, 1'b1);
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h want 0", out_data); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d want 0", out_ch); end
        checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL reset_overflow got %b want 0000", overflow); end
        checks++; if (lane_err !== 1'b0) begin errors++; $display("FAIL reset_lane_err got %0b want 0", lane_err); end
    endtask

    task automatic test_single_word();
        do_reset();
        out_ready = 1'b1;
        send_byte(2, 8'hA5);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", out_valid); end
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got %0h want a5", out_data); end
        checks++; if (out_ch !== 2'd2) begin errors++; $display("FAIL single_ch got %0d want 2", out_ch); end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %0b want 0", out_valid); end
        checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL single_overflow got %b want 0000", overflow); end
        checks++; if (lane_err !== 1'b0) begin errors++; $display("FAIL single_lane_err got %0b want 0", lane_err); end
    endtask

    task automatic test_interleave();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h3C; b = 8'hC3;
        do_reset();
        out_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send(0, a[i]);
            send(1, b[i]);
        end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd0) begin
            errors++; $display("FAIL interleave_first got v%0b %0h ch%0d want v1 3c ch0", out_valid, out_data, out_ch); end
        idle();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_ch !== 2'd1) begin
            errors++; $display("FAIL interleave_second got v%0b %0h ch%0d want v1 c3 ch1", out_valid, out_data, out_ch); end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL interleave_idle got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] v;
        v = 8'h67;   // bits 18..25: 0x33 without its dropped MSB, then a 1
        do_reset();
        out_ready = 1'b0;
        send_byte(3, 8'h11);
        send_byte(3, 8'h22);
        checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL bp_no_ovf got %b want 0000", overflow); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd3) begin
            errors++; $display("FAIL bp_hold got v%0b %0h ch%0d want v1 11 ch3", out_valid, out_data, out_ch); end
        send(3, 1'b0);
        checks++; if (overflow !== 4'b1000) begin errors++; $display("FAIL bp_ovf got %b want 1000", overflow); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++; $display("FAIL bp_still_hold got v%0b %0h want v1 11", out_valid, out_data); end
        out_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send(3, v[i]);
            if (i == 7) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_ch !== 2'd3) begin
                    errors++; $display("FAIL bp_second got v%0b %0h ch%0d want v1 22 ch3", out_valid, out_data, out_ch); end
            end
            if (i == 6) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_gap got %0b want 0", out_valid); end
            end
        end
        idle();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h67 || out_ch !== 2'd3) begin
            errors++; $display("FAIL bp_fresh got v%0b %0h ch%0d want v1 67 ch3", out_valid, out_data, out_ch); end
        checks++; if (overflow !== 4'b1000) begin errors++; $display("FAIL bp_ovf_sticky got %b want 1000", overflow); end
    endtask

    task automatic test_round_robin();
        logic [7:0] rr [4];
        logic [7:0] a;
        logic [7:0] b;
        rr[0] = 8'h10; rr[1] = 8'h21; rr[2] = 8'h32; rr[3] = 8'h43;
        a = 8'h96; b = 8'h5A;
        do_reset();
        out_ready = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            for (int c = 0; c < 4; c++) send(c, rr[c][i]);
        end
        checks++; if (out_valid !== 1'b1 || out_data !== rr[0] || out_ch !== 2'd0) begin
            errors++; $display("FAIL rr_ch0 got v%0b %0h ch%0d want v1 10 ch0", out_valid, out_data, out_ch); end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            idle();
            checks++; if (out_valid !== 1'b1 || out_data !== rr[k] || out_ch !== 2'(k)) begin
                errors++; $display("FAIL rr_seq got v%0b %0h ch%0d want v1 %0h ch%0d", out_valid, out_data, out_ch, rr[k], k); end
        end
        out_ready = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send(3, a[i]);
            send(0, b[i]);
        end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h43) begin
            errors++; $display("FAIL rr_refill_hold got v%0b %0h want v1 43", out_valid, out_data); end
        out_ready = 1'b1;
        idle();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_ch !== 2'd0) begin
            errors++; $display("FAIL rr_wrap_ch0 got v%0b %0h ch%0d want v1 5a ch0", out_valid, out_data, out_ch); end
        idle();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h96 || out_ch !== 2'd3) begin
            errors++; $display("FAIL rr_wrap_ch3 got v%0b %0h ch%0d want v1 96 ch3", out_valid, out_data, out_ch); end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drained got %0b want 0", out_valid); end
    endtask

    task automatic test_lane_err();
        do_reset();
        out_ready = 1'b1;
        bit_valid = 1'b0; lane_sel = 2'd0; lane_in = 4'b1111;
        step();
        checks++; if (lane_err !== 1'b0) begin errors++; $display("FAIL lerr_ignored got %0b want 0", lane_err); end
        bit_valid = 1'b1; lane_sel = 2'd1; lane_in = 4'b0110;
        step();
        checks++; if (lane_err !== 1'b1) begin errors++; $display("FAIL lerr_set got %0b want 1", lane_err); end
        for (int i = 0; i < 7; i++) send(1, 1'b0);
        checks++; if (lane_err !== 1'b1) begin errors++; $display("FAIL lerr_sticky got %0b want 1", lane_err); end
        idle();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h80 || out_ch !== 2'd1) begin
            errors++; $display("FAIL lerr_word got v%0b %0h ch%0d want v1 80 ch1", out_valid, out_data, out_ch); end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 1'b1);
        rst_n = 1'b0; bit_valid = 1'b0; lane_in = 4'b0000;
        step();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || overflow !== 4'b0000 || lane_err !== 1'b0) begin
            errors++; $display("FAIL midreset_zero got v%0b %0h ch%0d ov%b le%0b want all 0", out_valid, out_data, out_ch, overflow, lane_err); end
        send_byte(0, 8'hF0);
        idle();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_ch !== 2'd0) begin
            errors++; $display("FAIL midreset_word got v%0b %0h ch%0d want v1 f0 ch0", out_valid, out_data, out_ch); end
    endtask

    task automatic test_random();
        int         c;
        logic       b;
        logic [3:0] noise;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            c     = int'($urandom_range(0, 3));
            b     = 1'($urandom_range(0, 1));
            noise = 4'($urandom_range(0, 15));
            bit_valid = ($urandom_range(0, 9) < 7);
            lane_sel  = 2'(c);
            if (bit_valid) begin
                lane_in = 4'({3'b000, b}) << c;
                if ($urandom_range(0, 49) == 0) lane_in = lane_in | noise;
            end else begin
                lane_in = noise;
            end
            out_ready = ($urandom_range(0, 9) < 5);
            rst_n     = ($urandom_range(0, 599) != 0);
            step();
            rst_n = 1'b1;
            checks++; if (out_valid !== m_vld) begin
                errors++; $display("FAIL rand_valid cyc %0d got %0b want %0b", n, out_valid, m_vld); end
            if (m_vld) begin
                checks++; if (out_data !== W'(m_dat) || out_ch !== 2'(m_ch)) begin
                    errors++; $display("FAIL rand_word cyc %0d got %0h ch%0d want %0h ch%0d", n, out_data, out_ch, m_dat, m_ch); end
            end
            checks++; if (overflow !== m_ov || lane_err !== m_le) begin
                errors++; $display("FAIL rand_flags cyc %0d got ov%b le%0b want ov%b le%0b", n, overflow, lane_err, m_ov, m_le); end
        end
    endtask

    initial begin
        rst_n = 1'b0; bit_valid = 1'b0; lane_sel = 2'd0; lane_in = 4'b0000; out_ready = 1'b0;
        test_reset();
        test_single_word();
        test_interleave();
        test_backpressure();
        test_round_robin();
        test_lane_err();
        test_reset_mid_word();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
